// File: rtl/sent_rx_store_arbiter_pkg.sv
// Shared constants for the SENT receive store arbiter: FIFO tags, slow completion codes, FSM states.
// Optional round-robin grant is selected by the SENT_RX_ARB_RR_EN macro in the top module.
package sent_rx_pkg;

    localparam int FAST_DEPTH_DEF = 4;

    localparam logic [1:0] TAG_FAST = 2'b01;
    localparam logic [1:0] TAG_SHDR = 2'b10;
    localparam logic [1:0] TAG_SDAT = 2'b11;

    localparam logic [2:0] SLOW_SHORT = 3'b100;
    localparam logic [2:0] SLOW_ENH   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_FAST = 2'd1,
        ST_WR_SHDR = 2'd2,
        ST_WR_SDAT = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] data;
        logic        fmt;
    } slow_msg_t;

    function automatic logic is_slow_code(input logic [2:0] code);
        return (code == SLOW_SHORT) || (code == SLOW_ENH);
    endfunction

endpackage

// File: rtl/sent_rx_store_arbiter_fast_buf.sv
// Circular buffer for fast-channel words; push visible to the reader the cycle after it is accepted.
// A push into a full buffer is accepted only when a pop happens in the same cycle, otherwise it is flagged as a drop.
module sent_rx_fast_buf
    import sent_rx_pkg::*;
#(
    parameter int DEPTH = FAST_DEPTH_DEF,
    parameter int W     = 12
) (
    input  logic         clk_rx,
    input  logic         reset_rx,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB separates the full and empty cases when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && !do_push;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/sent_rx_store_arbiter.sv
// Merges fast words and slow messages into one store FIFO; slow header/data pairs are written back to back.
// Define SENT_RX_ARB_RR_EN for round-robin grant; otherwise fast words have fixed priority over slow messages.
module sent_rx_store_arbiter
    import sent_rx_pkg::*;
#(
    parameter int FAST_DEPTH = FAST_DEPTH_DEF,
    parameter int DROP_W     = 8
) (
    input  logic              clk_rx,
    input  logic              reset_rx,
    input  logic              fast_we,
    input  logic [11:0]       fast_data,
    input  logic [2:0]        slow_done,
    input  logic [7:0]        slow_id,
    input  logic [15:0]       slow_data,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [17:0]       fifo_wdata,
    output logic [DROP_W-1:0] fast_drop_cnt,
    output logic [DROP_W-1:0] slow_drop_cnt,
    output logic              busy
);

    arb_state_t  state;
    logic [2:0]  slow_done_q;
    logic        slow_new;
    logic        slow_vld;
    slow_msg_t   slow_msg;

    logic        fast_pop;
    logic [11:0] fast_rd_data;
    logic        fast_full;
    logic        fast_empty;
    logic        fast_drop;

    logic        grant_fast;
    logic        grant_slow;

`ifdef SENT_RX_ARB_RR_EN
    logic        last_fast;
`endif

    sent_rx_fast_buf #(
        .DEPTH (FAST_DEPTH),
        .W     (12)
    ) u_fast_buf (
        .clk_rx    (clk_rx),
        .reset_rx  (reset_rx),
        .push      (fast_we),
        .push_data (fast_data),
        .pop       (fast_pop),
        .pop_data  (fast_rd_data),
        .full      (fast_full),
        .empty     (fast_empty),
        .drop      (fast_drop)
    );

    // Only an edge into a valid completion code counts; a held code is one message.
    assign slow_new = is_slow_code(slow_done) && (slow_done != slow_done_q);
    assign fast_pop = (state == ST_WR_FAST) && !fifo_full;
    assign busy     = !fast_empty || slow_vld || (state != ST_IDLE);

`ifdef SENT_RX_ARB_RR_EN
    assign grant_slow = slow_vld && (fast_empty || last_fast);
`else
    assign grant_slow = slow_vld && fast_empty;
`endif
    assign grant_fast = !fast_empty && !grant_slow;

    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            state         <= ST_IDLE;
            slow_done_q   <= 3'b000;
            slow_vld      <= 1'b0;
            slow_msg      <= '0;
            fifo_wr       <= 1'b0;
            fifo_wdata    <= '0;
            fast_drop_cnt <= '0;
            slow_drop_cnt <= '0;
`ifdef SENT_RX_ARB_RR_EN
            last_fast     <= 1'b0;
`endif
        end else begin
            slow_done_q <= slow_done;
            fifo_wr     <= 1'b0;

            if (fast_drop && (fast_drop_cnt != {DROP_W{1'b1}})) begin
                fast_drop_cnt <= fast_drop_cnt + 1'b1;
            end

            // The holding register is never loaded and freed in the same cycle, so occupancy alone decides.
            if (slow_new) begin
                if (slow_vld) begin
                    if (slow_drop_cnt != {DROP_W{1'b1}}) begin
                        slow_drop_cnt <= slow_drop_cnt + 1'b1;
                    end
                end else begin
                    slow_vld      <= 1'b1;
                    slow_msg.id   <= slow_id;
                    slow_msg.data <= slow_data;
                    slow_msg.fmt  <= slow_done[0];
                end
            end

            case (state)
                ST_IDLE: begin
                    if (grant_fast) begin
                        state <= ST_WR_FAST;
`ifdef SENT_RX_ARB_RR_EN
                        last_fast <= 1'b1;
`endif
                    end else if (grant_slow) begin
                        state <= ST_WR_SHDR;
`ifdef SENT_RX_ARB_RR_EN
                        last_fast <= 1'b0;
`endif
                    end
                end
                ST_WR_FAST: begin
                    if (!fifo_full) begin
                        fifo_wr    <= 1'b1;
                        fifo_wdata <= {TAG_FAST, 4'h0, fast_rd_data};
                        state      <= ST_IDLE;
                    end
                end
                ST_WR_SHDR: begin
                    if (!fifo_full) begin
                        fifo_wr    <= 1'b1;
                        fifo_wdata <= {TAG_SHDR, slow_msg.fmt, 7'b0, slow_msg.id};
                        state      <= ST_WR_SDAT;
                    end
                end
                ST_WR_SDAT: begin
                    if (!fifo_full) begin
                        fifo_wr    <= 1'b1;
                        fifo_wdata <= {TAG_SDAT, slow_msg.data};
                        slow_vld   <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sent_rx_store_arbiter.sv
// Scoreboard bench for sent_rx_store_arbiter: expected FIFO words are queued as stimulus is applied.
module tb_sent_rx_store_arbiter;

    logic        clk_rx = 1'b0;
    logic        reset_rx;
    logic        fast_we;
    logic [11:0] fast_data;
    logic [2:0]  slow_done;
    logic [7:0]  slow_id;
    logic [15:0] slow_data;
    logic        fifo_full;
    logic        fifo_wr;
    logic [17:0] fifo_wdata;
    logic [7:0]  fast_drop_cnt;
    logic [7:0]  slow_drop_cnt;
    logic        busy;

    logic [17:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;

    sent_rx_store_arbiter #(.FAST_DEPTH(4), .DROP_W(8)) dut (
        .clk_rx        (clk_rx),
        .reset_rx      (reset_rx),
        .fast_we       (fast_we),
        .fast_data     (fast_data),
        .slow_done     (slow_done),
        .slow_id       (slow_id),
        .slow_data     (slow_data),
        .fifo_full     (fifo_full),
        .fifo_wr       (fifo_wr),
        .fifo_wdata    (fifo_wdata),
        .fast_drop_cnt (fast_drop_cnt),
        .slow_drop_cnt (slow_drop_cnt),
        .busy          (busy)
    );

    always #5 clk_rx = ~clk_rx;

    // Every FIFO write must match the oldest expected word.
    always @(negedge clk_rx) begin
        if (fifo_wr === 1'b1) begin
            logic [17:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got=%h expected=none", fifo_wdata);
            end else begin
                e = exp_q.pop_front();
                if (fifo_wdata !== e) begin
                    errors++;
                    $display("FAIL fifo_word got=%h expected=%h", fifo_wdata, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk_rx);
        reset_rx  = 1'b1;
        fast_we   = 1'b0;
        slow_done = 3'b000;
        fifo_full = 1'b0;
        @(negedge clk_rx);
        reset_rx  = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_idle(input int limit, output int cycles);
        cycles = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && cycles < limit) begin
            @(negedge clk_rx);
            cycles++;
        end
        @(negedge clk_rx);
    endtask

    task automatic test_reset();
        @(negedge clk_rx);
        reset_rx  = 1'b1;
        fast_we   = 1'b1;
        fast_data = 12'h777;
        slow_done = 3'b101;
        slow_id   = 8'h11;
        slow_data = 16'h2222;
        fifo_full = 1'b0;
        @(negedge clk_rx);
        reset_rx  = 1'b0;
        fast_we   = 1'b0;
        slow_done = 3'b000;
        checks++;
        if (fifo_wr !== 1'b0 || fifo_wdata !== 18'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%b wdata=%h busy=%b expected 0/0/0", fifo_wr, fifo_wdata, busy);
        end
        checks++;
        if (fast_drop_cnt !== 8'h0 || slow_drop_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_counters got fast=%h slow=%h expected 00/00", fast_drop_cnt, slow_drop_cnt);
        end
        repeat (3) @(negedge clk_rx);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_inputs_ignored got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk_rx);
        fast_we   = 1'b1;
        fast_data = 12'hABC;
        exp_q.push_back(18'h10ABC);
        @(negedge clk_rx);
        fast_we = 1'b0;
        checks++;
        if (fifo_wr !== 1'b0) begin
            errors++;
            $display("FAIL single_lat0 got wr=%b expected 0", fifo_wr);
        end
        @(negedge clk_rx);
        checks++;
        if (fifo_wr !== 1'b0) begin
            errors++;
            $display("FAIL single_lat1 got wr=%b expected 0", fifo_wr);
        end
        @(negedge clk_rx);
        checks++;
        if (fifo_wr !== 1'b1 || fifo_wdata !== 18'h10ABC) begin
            errors++;
            $display("FAIL single_lat2 got wr=%b wdata=%h expected 1/10abc", fifo_wr, fifo_wdata);
        end
        @(negedge clk_rx);
        checks++;
        if (fifo_wr !== 1'b0 || fifo_wdata !== 18'h10ABC || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after got wr=%b wdata=%h busy=%b expected 0/10abc/0", fifo_wr, fifo_wdata, busy);
        end
    endtask

    task automatic test_fast_full();
        int          n;
        logic [11:0] d;
        do_reset();
        fifo_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_rx);
            d         = 12'h100 + 12'(i * 17);
            fast_we   = 1'b1;
            fast_data = d;
            if (i < 4) exp_q.push_back({2'b01, 4'h0, d});
        end
        // Full buffer with a pop in the same cycle must take the new word.
        @(negedge clk_rx);
        fifo_full = 1'b0;
        fast_data = 12'hF0F;
        exp_q.push_back(18'h10F0F);
        @(negedge clk_rx);
        fast_we = 1'b0;
        wait_idle(60, n);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got pending=%0d busy=%b expected 0/0", exp_q.size(), busy);
        end
        checks++;
        if (fast_drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL full_drop_cnt got=%0d expected=2", fast_drop_cnt);
        end
    endtask

    task automatic test_slow_atomic();
        int n;
        do_reset();
        @(negedge clk_rx);
        slow_done = 3'b101;
        slow_id   = 8'h5A;
        slow_data = 16'h1234;
        exp_q.push_back(18'h2805A);
        exp_q.push_back(18'h31234);
        @(negedge clk_rx);
        slow_done = 3'b000;
        for (int i = 0; i < 3; i++) begin
            fast_we   = 1'b1;
            fast_data = 12'h3C0 + 12'(i);
            exp_q.push_back({2'b01, 4'h0, 12'h3C0 + 12'(i)});
            @(negedge clk_rx);
        end
        fast_we = 1'b0;
        wait_idle(60, n);
        checks++;
        if (exp_q.size() != 0 || slow_drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL slow_atomic got pending=%0d drops=%0d expected 0/0", exp_q.size(), slow_drop_cnt);
        end
        // Codes other than 100/101 are ignored.
        @(negedge clk_rx);
        slow_done = 3'b110;
        @(negedge clk_rx);
        slow_done = 3'b000;
        @(negedge clk_rx);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL slow_bad_code got busy=%b expected 0", busy);
        end
        @(negedge clk_rx);
        slow_done = 3'b100;
        slow_id   = 8'h33;
        slow_data = 16'hBEEF;
        exp_q.push_back(18'h20033);
        exp_q.push_back(18'h3BEEF);
        @(negedge clk_rx);
        slow_done = 3'b000;
        wait_idle(60, n);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL slow_short got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_arb_order();
        int n;
        do_reset();
        fifo_full = 1'b1;
        @(negedge clk_rx);
        fast_we   = 1'b1;
        fast_data = 12'h0F1;
        @(negedge clk_rx);
        fast_we   = 1'b0;
        slow_done = 3'b101;
        slow_id   = 8'h11;
        slow_data = 16'h2222;
        @(negedge clk_rx);
        slow_done = 3'b000;
        fast_we   = 1'b1;
        fast_data = 12'h0F2;
        @(negedge clk_rx);
        fast_we = 1'b0;
        exp_q.push_back(18'h100F1);
`ifdef SENT_RX_ARB_RR_EN
        exp_q.push_back(18'h28011);
        exp_q.push_back(18'h32222);
        exp_q.push_back(18'h100F2);
`else
        exp_q.push_back(18'h100F2);
        exp_q.push_back(18'h28011);
        exp_q.push_back(18'h32222);
`endif
        @(negedge clk_rx);
        fifo_full = 1'b0;
        wait_idle(60, n);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_order got pending=%0d busy=%b expected 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_slow_saturate();
        int n;
        do_reset();
        fifo_full = 1'b1;
        @(negedge clk_rx);
        slow_done = 3'b100;
        slow_id   = 8'hA5;
        slow_data = 16'h0F0F;
        exp_q.push_back(18'h200A5);
        exp_q.push_back(18'h30F0F);
        for (int i = 0; i < 260; i++) begin
            @(negedge clk_rx);
            slow_done = 3'b000;
            @(negedge clk_rx);
            slow_done = (i % 2 == 0) ? 3'b101 : 3'b100;
            slow_id   = 8'(i);
            slow_data = 16'(i * 3);
            if (i == 9) begin
                checks++;
                if (slow_drop_cnt !== 8'd9) begin
                    errors++;
                    $display("FAIL slow_drop_mid got=%0d expected=9", slow_drop_cnt);
                end
            end
        end
        @(negedge clk_rx);
        slow_done = 3'b000;
        checks++;
        if (slow_drop_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL slow_drop_sat got=%h expected=ff", slow_drop_cnt);
        end
        fifo_full = 1'b0;
        wait_idle(60, n);
        checks++;
        if (exp_q.size() != 0 || slow_drop_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL slow_sat_drain got pending=%0d drops=%h expected 0/ff", exp_q.size(), slow_drop_cnt);
        end
    endtask

    task automatic test_reset_sdat();
        int n;
        do_reset();
        @(negedge clk_rx);
        slow_done = 3'b101;
        slow_id   = 8'h77;
        slow_data = 16'h9999;
        exp_q.push_back(18'h28077);
        @(negedge clk_rx);
        slow_done = 3'b000;
        n = 0;
        while (fifo_wr !== 1'b1 && n < 10) begin
            @(negedge clk_rx);
            n++;
        end
        checks++;
        if (fifo_wr !== 1'b1) begin
            errors++;
            $display("FAIL rst_sdat_header got wr=%b expected 1", fifo_wr);
        end
        reset_rx  = 1'b1;
        fifo_full = 1'b1;
        @(negedge clk_rx);
        reset_rx  = 1'b0;
        fifo_full = 1'b0;
        checks++;
        if (fifo_wr !== 1'b0 || busy !== 1'b0 || fifo_wdata !== 18'h0 ||
            fast_drop_cnt !== 8'h0 || slow_drop_cnt !== 8'h0) begin
            errors++;
            $display("FAIL rst_sdat_state got wr=%b busy=%b wdata=%h fd=%h sd=%h expected all 0",
                     fifo_wr, busy, fifo_wdata, fast_drop_cnt, slow_drop_cnt);
        end
        exp_q.delete();
        @(negedge clk_rx);
        fast_we   = 1'b1;
        fast_data = 12'h5A5;
        exp_q.push_back(18'h105A5);
        @(negedge clk_rx);
        fast_we = 1'b0;
        wait_idle(30, n);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_sdat_after got pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int          n;
        logic [11:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_rx);
            d         = 12'($urandom_range(0, 4095));
            fast_we   = 1'b1;
            fast_data = d;
            exp_q.push_back({2'b01, 4'h0, d});
        end
        @(negedge clk_rx);
        fast_we = 1'b0;
        wait_idle(40, n);
        checks++;
        if (exp_q.size() != 0 || n > 6) begin
            errors++;
            $display("FAIL back_to_back got pending=%0d cycles=%0d expected 0/<=6", exp_q.size(), n);
        end
    endtask

    initial begin
        reset_rx  = 1'b1;
        fast_we   = 1'b0;
        fast_data = 12'h0;
        slow_done = 3'b000;
        slow_id   = 8'h0;
        slow_data = 16'h0;
        fifo_full = 1'b0;
        test_reset();
        test_single();
        test_fast_full();
        test_slow_atomic();
        test_arb_order();
        test_slow_saturate();
        test_reset_sdat();
        test_back_to_back();
        repeat (2) @(negedge clk_rx);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sent_rx_store_arbiter.md
SENT_RX_STORE_ARBITER -- requirements
Module: sent_rx_store_arbiter

Interface
REQ-001 Parameter FAST_DEPTH, 4, fast-word buffer entries; power of two, minimum 2.
REQ-002 Parameter DROP_W, 8, width of each drop counter.
REQ-003 clk_rx  in  1  sole clock; all logic on rising edge.
REQ-004 reset_rx  in  1  reset; synchronous, active-high.
REQ-005 fast_we  in  1  one-cycle pulse: fast-channel 12-bit word valid.
REQ-006 fast_data  in  12  fast-channel word; sampled when fast_we=1.
REQ-007 slow_done  in  3  slow-message completion code; 3'b100 = short serial, 3'b101 = enhanced; other values are ignored.
REQ-008 slow_id  in  8  slow-message ID; sampled on a valid slow_done code.
REQ-009 slow_data  in  16  slow-message data; sampled on a valid slow_done code.
REQ-010 fifo_full  in  1  shared store FIFO cannot accept a write this cycle.
REQ-011 fifo_wr  out  1  write strobe to the shared store FIFO.
REQ-012 fifo_wdata  out  18  FIFO word = {tag[1:0], payload[15:0]}.
REQ-013 fast_drop_cnt  out  DROP_W  saturating count of discarded fast words.
REQ-014 slow_drop_cnt  out  DROP_W  saturating count of discarded slow messages.
REQ-015 busy  out  1  high when any buffer is non-empty or the FSM is not in IDLE.

Function
REQ-016 Fast path: fast_we=1 pushes fast_data into a FAST_DEPTH circular buffer in the same cycle.
REQ-017 Slow path: a rising transition of slow_done into 3'b100 or 3'b101 (previous cycle value differs) loads the 1-entry slow holding register with {id, data, fmt bit}.
REQ-018 Tags: 2'b01 fast word {4'h0, data[11:0]}; 2'b10 slow header {fmt, 7'b0, id[7:0]}; 2'b11 slow data[15:0].
REQ-019 FSM states: IDLE, WR_FAST, WR_SHDR, WR_SDAT.
REQ-020 In IDLE, when the grant source is non-empty, the FSM moves to WR_FAST or WR_SHDR; otherwise it stays in IDLE.
REQ-021 In WR_FAST with fifo_full=0: fifo_wr=1, pop one fast word, return to IDLE.
REQ-022 In WR_SHDR with fifo_full=0: write the header and go to WR_SDAT.
REQ-023 In WR_SDAT with fifo_full=0: write the data word, free the slow register, return to IDLE.
REQ-024 In any WR_* state with fifo_full=1: fifo_wr=0 and state, data and buffers hold.
REQ-025 A slow message is atomic: no fast word is written between its header and data.
REQ-026 fifo_wr and fifo_wdata are registered outputs; fifo_wdata holds its last value when fifo_wr=0.
REQ-027 Latency with an empty buffer and fifo_full=0: a push in cycle N gives fifo_wr=1 in cycle N+2.
REQ-028 Sustained throughput is one fast word per 2 cycles.
REQ-029 Fast buffer full with no pop in the same cycle: the push is discarded and fast_drop_cnt increments.
REQ-030 Fast buffer full with a pop in the same cycle: the push is accepted; no drop.
REQ-031 New slow message while the slow register is occupied (including during WR_SHDR/WR_SDAT): the new message is discarded and slow_drop_cnt increments.
REQ-032 Drop counters saturate at all-ones and do not wrap.
REQ-033 Fast buffer read and write pointers are log2(FAST_DEPTH)+1 bits; full and empty derive from the MSB compare; pointers wrap modulo 2*FAST_DEPTH.

Reset
REQ-034 reset_rx=1 at a clock edge clears buffers, pointers, counters and the slow register, forces FSM to IDLE, and sets fifo_wr=0, fifo_wdata=0, busy=0.
REQ-035 Reset during WR_SDAT abandons the message; the orphan header is acceptable, and downstream discards any header not followed by a tag-11 word.
REQ-036 Inputs presented in the reset cycle are ignored.

Configuration
REQ-037 Macro SENT_RX_ARB_RR_EN defined: round-robin grant; the last-served source has low priority, and the initial preference after reset is fast.
REQ-038 Macro SENT_RX_ARB_RR_EN undefined: fixed priority; the slow message is granted only when the fast buffer is empty.

Structure
REQ-039 Package sent_rx_pkg SHALL hold the tag constants, the FSM state enum, the slow_done codes 3'b100/3'b101, and the default FAST_DEPTH.
REQ-040 The fast buffer SHALL be the sub-module sent_rx_fast_buf (push, pop, data, full, empty); the arbiter FSM stays in the top module.

Verification
REQ-041 Single fast_we with data 12'hABC into an idle block, fifo_full=0 -> exactly one fifo_wr with 18'h10ABC, two cycles after the pulse.
REQ-042 Six fast_we pulses on consecutive cycles, fifo_full=1 throughout -> four words are kept, fast_drop_cnt=2, then fifo_full=0 drains 4 words in order.
REQ-043 slow_done=3'b101, id 8'h5A, data 16'h1234 -> writes 18'h2805A then 18'h31234 on consecutive strobes, with no fast word between them even while fast_we pulses arrive.
REQ-044 With RR enabled, fast and slow pending together -> order fast, slow header, slow data, fast; with RR disabled, all fast words are written before the slow pair.
REQ-045 Slow message pending and fifo_full held high, plus 260 further slow messages -> slow_drop_cnt saturates at 8'hFF.
REQ-046 reset_rx asserted in WR_SDAT -> the next cycle shows fifo_wr=0, busy=0, counters 0; a following fast word is written normally.
